fa8_rev_driver: RTL and testbench

FA8_REV_DRIVER -- requirements
Module: fa8_rev_driver

---
 rtl/fa8_rev_driver.sv | 256 +++++++++++++++++++++++++
 tb/tb_fa8_rev_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa8_rev_driver.sv
// fa8_rev_driver
// Sequencer for an external 8-bit dual-rail reversible ripple adder.
// One operation runs FWD -> NULL1 -> BWD -> NULL2 -> DONE. Each phase is held
// for SETTLE cycles. The forward result is captured at the end of FWD. It is
// then driven back through the array, and the recovered operand is compared
// with the original at the end of BWD. Illegal dual-rail codes (00/11) seen on
// any sampled pair raise out_rail_err. A recovery mismatch raises out_rev_err.

module fa8_rev_driver #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,

    // operand handshake
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_cin,

    // result handshake
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_cout,
    output logic       out_rail_err,
    output logic       out_rev_err,

    // forward drive
    output logic [7:0] fa_a,
    output logic [7:0] fa_a_not,
    output logic [7:0] fa_b,
    output logic [7:0] fa_b_not,
    output logic       fa_c0_f,
    output logic       fa_c0_f_not,

    // forward sense
    input  logic [7:0] fa_s,
    input  logic [7:0] fa_s_not,
    input  logic       fa_c7,
    input  logic       fa_c7_not,

    // backward drive
    output logic [7:0] fa_s_bwd,
    output logic [7:0] fa_s_not_bwd,
    output logic       fa_c7_bwd,
    output logic       fa_c7_not_bwd,
    output logic       fa_bwd_en,

    // backward sense
    input  logic [7:0] fa_a_b,
    input  logic [7:0] fa_a_not_b,
    input  logic       fa_c0_b,
    input  logic       fa_c0_not_b
);

    // Final count value of a phase. The counter runs 0..SETTLE-1.
    localparam logic [3:0] PHASE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FWD   = 3'd1,
        NULL1 = 3'd2,
        BWD   = 3'd3,
        NULL2 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Latched operands, kept for the forward drive and the recovery compare
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       cin_reg;

    // Captured forward result and sticky error flags
    logic [7:0] sum_reg;
    logic       cout_reg;
    logic       rail_err_reg;
    logic       rev_err_reg;

    // Registered rail enables. They are decoded from state_next, so the pads
    // see clean flop outputs rather than a decode of the encoded state.
    logic       fwd_drive_reg;
    logic       bwd_drive_reg;

    logic       phase_last;
    logic       accept;
    logic       fwd_sample;
    logic       bwd_sample;

    // Per-bit illegal-code detection on the sensed dual-rail pairs
    logic [7:0] fwd_pair_bad;
    logic [7:0] bwd_pair_bad;
    logic       fwd_rail_bad;
    logic       bwd_rail_bad;
    logic       rev_mismatch;

    assign phase_last = (cnt_reg == PHASE_LAST);
    assign accept     = (state_reg == IDLE) && in_valid;
    assign fwd_sample = (state_reg == FWD) && phase_last;
    assign bwd_sample = (state_reg == BWD) && phase_last;

    assign in_ready     = (state_reg == IDLE);
    assign out_valid    = (state_reg == DONE);
    assign out_sum      = sum_reg;
    assign out_cout     = cout_reg;
    assign out_rail_err = rail_err_reg;
    assign out_rev_err  = rev_err_reg;

    // State and phase-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. Each timed phase holds for SETTLE cycles and then
    // hands over with the counter cleared.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 4'd0;
                if (in_valid) begin
                    state_next = FWD;
                end
            end
            FWD: begin
                if (phase_last) begin
                    state_next = NULL1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            NULL1: begin
                if (phase_last) begin
                    state_next = BWD;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            BWD: begin
                if (phase_last) begin
                    state_next = NULL2;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            NULL2: begin
                if (phase_last) begin
                    state_next = DONE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                cnt_next = 4'd0;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Rail enables follow the state being entered, so they change on the same
    // edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_drive_reg <= 1'b0;
            bwd_drive_reg <= 1'b0;
        end else begin
            fwd_drive_reg <= (state_next == FWD);
            bwd_drive_reg <= (state_next == BWD);
        end
    end

    // Per-bit rail drive and illegal-code detection. The drive is true/not
    // encoded while its phase enable is set and all-zero (spacer) otherwise.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign fa_a[gi]         = fwd_drive_reg &  a_reg[gi];
            assign fa_a_not[gi]     = fwd_drive_reg & ~a_reg[gi];
            assign fa_b[gi]         = fwd_drive_reg &  b_reg[gi];
            assign fa_b_not[gi]     = fwd_drive_reg & ~b_reg[gi];
            assign fa_s_bwd[gi]     = bwd_drive_reg &  sum_reg[gi];
            assign fa_s_not_bwd[gi] = bwd_drive_reg & ~sum_reg[gi];

            assign fwd_pair_bad[gi] = ~(fa_s[gi]   ^ fa_s_not[gi]);
            assign bwd_pair_bad[gi] = ~(fa_a_b[gi] ^ fa_a_not_b[gi]);
        end
    endgenerate

    assign fa_c0_f       = fwd_drive_reg &  cin_reg;
    assign fa_c0_f_not   = fwd_drive_reg & ~cin_reg;
    assign fa_c7_bwd     = bwd_drive_reg &  cout_reg;
    assign fa_c7_not_bwd = bwd_drive_reg & ~cout_reg;
    assign fa_bwd_en     = bwd_drive_reg;

    assign fwd_rail_bad = (|fwd_pair_bad) | ~(fa_c7   ^ fa_c7_not);
    assign bwd_rail_bad = (|bwd_pair_bad) | ~(fa_c0_b ^ fa_c0_not_b);
    assign rev_mismatch = (fa_a_b != a_reg) || (fa_c0_b != cin_reg);

    // Operand latch, result capture and sticky error flags. The flags clear
    // on each accept so they describe only the operation now in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg        <= 8'd0;
            b_reg        <= 8'd0;
            cin_reg      <= 1'b0;
            sum_reg      <= 8'd0;
            cout_reg     <= 1'b0;
            rail_err_reg <= 1'b0;
            rev_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                a_reg        <= in_a;
                b_reg        <= in_b;
                cin_reg      <= in_cin;
                rail_err_reg <= 1'b0;
                rev_err_reg  <= 1'b0;
            end
            if (fwd_sample) begin
                sum_reg  <= fa_s;
                cout_reg <= fa_c7;
                if (fwd_rail_bad) begin
                    rail_err_reg <= 1'b1;
                end
            end
            if (bwd_sample) begin
                if (bwd_rail_bad) begin
                    rail_err_reg <= 1'b1;
                end
                if (rev_mismatch) begin
                    rev_err_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fa8_rev_driver.sv
// Testbench for fa8_rev_driver. A behavioural model of the dual-rail
// reversible adder array sits on the fa_* pins. Each operation pushes its
// hand-computed result into a scoreboard queue. A negedge monitor pops an entry
// and compares it on every out_valid/out_ready transfer.

module tb_fa8_rev_driver;

    localparam int SETTLE = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_rail_err;
    logic       out_rev_err;
    logic [7:0] fa_a, fa_a_not, fa_b, fa_b_not;
    logic       fa_c0_f, fa_c0_f_not;
    logic [7:0] fa_s, fa_s_not;
    logic       fa_c7, fa_c7_not;
    logic [7:0] fa_s_bwd, fa_s_not_bwd;
    logic       fa_c7_bwd, fa_c7_not_bwd, fa_bwd_en;
    logic [7:0] fa_a_b, fa_a_not_b;
    logic       fa_c0_b, fa_c0_not_b;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       rail;
        logic       rev;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    fa8_rev_driver #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_rail_err(out_rail_err), .out_rev_err(out_rev_err),
        .fa_a(fa_a), .fa_a_not(fa_a_not), .fa_b(fa_b), .fa_b_not(fa_b_not),
        .fa_c0_f(fa_c0_f), .fa_c0_f_not(fa_c0_f_not),
        .fa_s(fa_s), .fa_s_not(fa_s_not), .fa_c7(fa_c7), .fa_c7_not(fa_c7_not),
        .fa_s_bwd(fa_s_bwd), .fa_s_not_bwd(fa_s_not_bwd),
        .fa_c7_bwd(fa_c7_bwd), .fa_c7_not_bwd(fa_c7_not_bwd), .fa_bwd_en(fa_bwd_en),
        .fa_a_b(fa_a_b), .fa_a_not_b(fa_a_not_b),
        .fa_c0_b(fa_c0_b), .fa_c0_not_b(fa_c0_not_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- adder array model ----------------
    logic       force_rail;   // forces fa_s[3] pair to 11 during FWD
    logic [7:0] flip_mask;    // corrupts the recovered operand (both rails)
    logic [7:0] mem_b;
    logic       mem_cin;
    logic       fwd_active;
    logic [8:0] fsum;
    logic [8:0] rec;
    logic [7:0] a_rec;
    logic [10:0] rail_or;

    assign fwd_active = |(fa_a | fa_a_not);
    assign fsum  = {1'b0, fa_a} + {1'b0, fa_b} + {8'd0, fa_c0_f};
    assign rec   = {fa_c7_bwd, fa_s_bwd} - {1'b0, mem_b} - {8'd0, mem_cin};
    assign a_rec = rec[7:0] ^ flip_mask;
    assign rail_or = {|fa_a, |fa_a_not, |fa_b, |fa_b_not, fa_c0_f, fa_c0_f_not,
                      |fa_s_bwd, |fa_s_not_bwd, fa_c7_bwd, fa_c7_not_bwd, fa_bwd_en};

    always_comb begin
        fa_s      = 8'd0;
        fa_s_not  = 8'd0;
        fa_c7     = 1'b0;
        fa_c7_not = 1'b0;
        if (fwd_active) begin
            fa_s      = fsum[7:0];
            fa_s_not  = ~fsum[7:0];
            fa_c7     = fsum[8];
            fa_c7_not = ~fsum[8];
            if (force_rail) begin
                fa_s[3]     = 1'b1;
                fa_s_not[3] = 1'b1;
            end
        end
    end

    always_comb begin
        fa_a_b      = 8'd0;
        fa_a_not_b  = 8'd0;
        fa_c0_b     = 1'b0;
        fa_c0_not_b = 1'b0;
        if (fa_bwd_en) begin
            fa_a_b      = a_rec;
            fa_a_not_b  = ~a_rec;
            fa_c0_b     = mem_cin;
            fa_c0_not_b = ~mem_cin;
        end
    end

    // The array remembers b and cin from the forward pass for recovery
    always @(posedge clk) begin
        if (fwd_active) begin
            mem_b   <= fa_b;
            mem_cin <= fa_c0_f;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: pops one expected entry per result transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("result{cout,sum,rail,rev}",
                      32'({out_cout, out_sum, out_rail_err, out_rev_err}),
                      32'({mon_e.cout, mon_e.sum, mon_e.rail, mon_e.rev}));
            end
        end
    end

    // One complete operation. Called at posedge+1 with the DUT idle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] exp_sum, input logic exp_cout,
                         input logic exp_rail, input logic exp_rev, input int hold);
        exp_t e;
        int   cyc;
        int   bwd_cnt;
        e.sum  = exp_sum;
        e.cout = exp_cout;
        e.rail = exp_rail;
        e.rev  = exp_rev;
        exp_q.push_back(e);

        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("fwd_drive{a,a_not}", 32'({fa_a, fa_a_not}), 32'({a, ~a}));
        check("fwd_drive{b,b_not,c0,c0n,en}",
              32'({fa_b, fa_b_not, fa_c0_f, fa_c0_f_not, fa_bwd_en}),
              32'({b, ~b, cin, ~cin, 1'b0}));

        cyc = 0;
        bwd_cnt = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == SETTLE || cyc == 3 * SETTLE)
                check("spacer_all_rails_zero", 32'(rail_or), 32'd0);
            if (fa_bwd_en) begin
                bwd_cnt++;
                check("bwd_drive{c7,c7n,s,sn}",
                      32'({fa_c7_bwd, fa_c7_not_bwd, fa_s_bwd, fa_s_not_bwd}),
                      32'({exp_cout, ~exp_cout, exp_sum, ~exp_sum}));
                check("bwd_fwd_rails_zero", 32'(rail_or[10:5]), 32'd0);
            end
        end
        check("latency_cycles", 32'(cyc), 32'(4 * SETTLE));
        check("bwd_en_cycles", 32'(bwd_cnt), 32'(SETTLE));

        // Hold the result; a competing operand must be ignored
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = ~a; in_b = ~b;
            @(posedge clk); #1;
            check("done_hold{valid,ready,sum,cout,rail,rev}",
                  32'({out_valid, in_ready, out_sum, out_cout, out_rail_err, out_rev_err}),
                  32'({1'b1, 1'b0, exp_sum, exp_cout, exp_rail, exp_rev}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after_transfer{in_ready,out_valid}", 32'({in_ready, out_valid}), 32'b10);
        check("idle_fwd_rails_zero", 32'(rail_or), 32'd0);
    endtask

    // Bounded run time in case the design stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 8'd0; in_b = 8'd0; in_cin = 1'b0;
        force_rail = 1'b0; flip_mask = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset{in_ready,out_valid}", 32'({in_ready, out_valid}), 32'b10);
        check("reset{sum,cout,rail,rev}",
              32'({out_sum, out_cout, out_rail_err, out_rev_err}), 32'd0);
        check("reset_rails_zero", 32'(rail_or), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0x5A + 0x3C + 0 = 0x096
        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 0);
        // 0xFF + 0x01 + 1 = 0x101, carry-out boundary
        do_op(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1);
        // sum bit 3 is already 1, so the forced 11 pair leaves recovery intact
        force_rail = 1'b1;
        do_op(8'h08, 8'h00, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 0);
        force_rail = 1'b0;
        // recovered a corrupted in bit 0 on both rails, held 5 cycles in DONE
        flip_mask = 8'h01;
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, 5);
        flip_mask = 8'h00;

        // Reset in the middle of BWD must abort without a result
        in_a = 8'h77; in_b = 8'h11; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_in_bwd_en", 32'(fa_bwd_en), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rails_zero", 32'(rail_or), 32'd0);
        check("abort{in_ready,out_valid}", 32'({in_ready, out_valid}), 32'b10);
        check("abort{sum,cout,rail,rev}",
              32'({out_sum, out_cout, out_rail_err, out_rev_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check("abort_no_out_valid", 32'(seen_valid), 32'd0);
        check("abort_idle_in_ready", 32'(in_ready), 32'd1);

        // 0xA5 + 0x5A + 1 = 0x100; flags from the earlier error run are cleared
        do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
